// File: rtl/write_decoder_regfile_16_if.sv
// Write/clear request and dual read-port bundle for the 16-entry register file.
// master drives requests and read IDs; slave returns ready, busy, wordline and read data.
interface write_decoder_regfile_16_if #(
  parameter int DATA_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_regid;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;
  logic [15:0]       wordline;
  logic [3:0]        rd_regid_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [3:0]        rd_regid_b;
  logic [DATA_W-1:0] rd_data_b;

  modport master (
    output wr_valid, wr_regid, wr_data, clr_req, rd_regid_a, rd_regid_b,
    input  wr_ready, busy, wordline, rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_valid, wr_regid, wr_data, clr_req, rd_regid_a, rd_regid_b,
    output wr_ready, busy, wordline, rd_data_a, rd_data_b
  );
endinterface

// File: rtl/write_decoder_regfile_16.sv
// 16-entry register file write side: one-hot wordline decode, 1-cycle commit, 16-cycle sweep-clear.
// Reads are combinational with write bypass; wr_ready drops while clearing or when clr_req is seen.
module write_decoder_regfile_16 #(
  parameter int DATA_W  = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  write_decoder_regfile_16_if.slave  bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              busy_q;
  logic [15:0]       wordline_q;
  logic [DATA_W-1:0] regs [16];

  logic accept;
  logic commit;

  assign bus.wr_ready = (state == IDLE) && !bus.clr_req;
  assign accept       = bus.wr_valid && bus.wr_ready;
  // r0 writes still handshake and pulse the wordline, but never land in the array
  assign commit       = accept && !(ZERO_R0 && (bus.wr_regid == 4'h0));
  assign bus.busy     = busy_q;
  assign bus.wordline = wordline_q;

  always_comb begin
    bus.rd_data_a = regs[bus.rd_regid_a];
    if ((state == CLEAR) && (bus.rd_regid_a == cnt)) bus.rd_data_a = '0;
    if (commit && (bus.wr_regid == bus.rd_regid_a))  bus.rd_data_a = bus.wr_data;
  end

  always_comb begin
    bus.rd_data_b = regs[bus.rd_regid_b];
    if ((state == CLEAR) && (bus.rd_regid_b == cnt)) bus.rd_data_b = '0;
    if (commit && (bus.wr_regid == bus.rd_regid_b))  bus.rd_data_b = bus.wr_data;
  end

  // wordline is loaded one edge ahead during the sweep so it lines up with busy and cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'h0;
      busy_q     <= 1'b0;
      wordline_q <= 16'h0000;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state      <= CLEAR;
            busy_q     <= 1'b1;
            cnt        <= 4'h0;
            wordline_q <= 16'h0001;
          end else begin
            wordline_q <= accept ? (16'h0001 << bus.wr_regid) : 16'h0000;
          end
          if (commit) regs[bus.wr_regid] <= bus.wr_data;
        end
        CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 4'd1;
          if (cnt == 4'hF) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            wordline_q <= 16'h0000;
          end else begin
            wordline_q <= 16'h0001 << (cnt + 4'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/write_decoder_regfile_16.md
Name: write_decoder_regfile_16

Overview:
- Write side of the 16x16 register file.
- Accepts write requests over a valid/ready handshake and decodes the 4-bit destination ID into a one-hot 16-bit write wordline.
- Commits data to the register array and exposes two bypassed read ports for the decode stage.
- Supports a sequential 16-cycle sweep-clear operation driven by a small state machine.

Parameters:
- DATA_W, 16, width of each register and of write/read data.
- ZERO_R0, 1, when 1 writes to register 0 are discarded and register 0 always reads 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  block can accept a write this cycle.
- wr_regid  input  4  destination register ID.
- wr_data  input  DATA_W  write data.
- clr_req  input  1  single-cycle pulse; starts a sweep-clear of all registers.
- busy  output  1  high while a sweep-clear is in progress.
- wordline  output  16  registered one-hot wordline of the last committed write; all zero when no write committed that cycle.
- rd_regid_a  input  4  read port A register ID.
- rd_data_a  output  DATA_W  read port A data.
- rd_regid_b  input  4  read port B register ID.
- rd_data_b  output  DATA_W  read port B data.

Behaviour:
- Reset (rst high at a clock edge):
  - all 16 registers = 0, state = IDLE, sweep counter = 0.
  - wordline = 16'h0000, busy = 0, wr_ready = 1 from the first cycle after reset.
  - rst high mid-sweep aborts the sweep; registers are zeroed by reset anyway.
- States:
  - IDLE: wr_ready = 1, busy = 0.
  - CLEAR: wr_ready = 0, busy = 1.
- IDLE -> CLEAR when clr_req = 1.
  - clr_req has priority over wr_valid in the same cycle; that write is not accepted because wr_ready is combinationally 0 when clr_req = 1 in IDLE.
- CLEAR sweep:
  - Counter starts at 0 and zeroes one register per cycle, from register 0 through register 15.
  - The counter increments modulo 16.
  - After register 15 is cleared (16 cycles in CLEAR), the state returns to IDLE.
  - clr_req while in CLEAR is ignored; it does not restart the sweep.
- Write accept: a write is accepted when wr_valid & wr_ready at a clock edge.
  - At that edge: register[wr_regid] <= wr_data, and wordline <= one-hot(wr_regid), i.e. bit n is set iff wr_regid == n.
  - Commit latency is 1 cycle.
  - wordline is a one-cycle pulse and returns to 0 on the next edge unless another write is accepted.
- ZERO_R0 = 1, wr_regid = 0:
  - The handshake completes and wordline bit 0 pulses.
  - Register 0 is not modified.
- During CLEAR, wordline shows one-hot(counter) each cycle, indicating which register is being cleared.
- Reads (combinational):
  - rd_data_x = register[rd_regid_x].
  - Bypass: if a write is being accepted this cycle to the same ID, rd_data_x = wr_data. The bypass is suppressed when the ID is 0 and ZERO_R0 = 1.
  - During CLEAR, a read of the register being cleared this cycle returns 0.
  - Both ports reading the same ID return identical data.
- Widths: wr_data is stored unmodified; no sign or width conversion.

Test Plan:
- Reset then write: assert rst 2 cycles, write regid 4'h5 data 16'hBEEF -> wordline = 16'h0020 for 1 cycle; rd_regid_a = 5 reads 16'hBEEF on the next cycle.
- Bypass: write regid 4'hA data 16'h1234 while rd_regid_a = rd_regid_b = 4'hA -> both read 16'h1234 in the same cycle as the write.
- R0 discard (ZERO_R0 = 1): write regid 0 data 16'hFFFF -> wr_ready = 1, wordline = 16'h0001 pulse, rd_data_a for regid 0 = 16'h0000 in the same and all later cycles.
- Sweep-clear:
  - Stimulus: fill all registers with 16'hA5A5, pulse clr_req, hold wr_valid high during the sweep.
  - Required: busy high exactly 16 cycles, wr_ready = 0 throughout, no writes accepted, wordline walks 16'h0001 -> 16'h8000, and all registers read 0 afterward.
- Simultaneous events: clr_req and wr_valid (regid 3, data 16'h0007) in the same IDLE cycle -> write not accepted, register 3 unchanged before its sweep slot, then cleared.
- Reset mid-sweep: assert rst on sweep cycle 7 -> next cycle busy = 0, wr_ready = 1, wordline = 0, all registers read 0.
